// File: rtl/time_set_ctrl_pkg.sv
// Shared definitions for the front-panel time/calendar set sequencer:
// state encodings, button indices and blink_mask field positions.
package time_set_ctrl_pkg;

  localparam int unsigned BTN_W      = 4;
  localparam int unsigned BTN_MODE   = 0;
  localparam int unsigned BTN_UP     = 1;
  localparam int unsigned BTN_CANCEL = 2;
  localparam int unsigned BTN_CLR    = 3;

  localparam int unsigned FLD_W   = 4;
  localparam int unsigned FLD_HR  = 0;
  localparam int unsigned FLD_MIN = 1;
  localparam int unsigned FLD_MM  = 2;
  localparam int unsigned FLD_DD  = 3;

  localparam int unsigned MODE_W = 3;

  typedef enum logic [MODE_W-1:0] {
    ST_RUN     = 3'd0,
    ST_SET_HR  = 3'd1,
    ST_SET_MIN = 3'd2,
    ST_SET_MON = 3'd3,
    ST_SET_DAY = 3'd4
  } state_t;

  // One-hot field selected by a set state; zero outside the set states.
  function automatic logic [FLD_W-1:0] field_sel(input state_t st);
    logic [FLD_W-1:0] sel;
    sel = '0;
    case (st)
      ST_SET_HR:  sel[FLD_HR]  = 1'b1;
      ST_SET_MIN: sel[FLD_MIN] = 1'b1;
      ST_SET_MON: sel[FLD_MM]  = 1'b1;
      ST_SET_DAY: sel[FLD_DD]  = 1'b1;
      default:    sel = '0;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/time_set_ctrl_edge.sv
// Rising-edge detector for one synchronised button: one-cycle registered
// pulse, one cycle after the input rises.
module time_set_ctrl_edge (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic pulse
);

  logic prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      prev  <= 1'b0;
      pulse <= 1'b0;
    end else begin
      prev  <= din;
      pulse <= din & ~prev;
    end
  end

endmodule

// File: rtl/time_set_ctrl.sv
// Front-panel set sequencer: walks hour/minute/month/day, issues increment and
// seconds-clear strobes, freezes timekeeping while setting, drives blink masks.
module time_set_ctrl
  import time_set_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_S   = 30,
  parameter int unsigned REPEAT_DLY  = 4,
  parameter int unsigned REPEAT_RATE = 2,
  parameter int unsigned BLINK_DIV   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick_1hz,
  input  logic              tick_fast,
  input  logic [BTN_W-1:0]  btn,
  output logic [MODE_W-1:0] mode,
  output logic              run_en,
  output logic              inc_hr,
  output logic              inc_min,
  output logic              inc_mm,
  output logic              inc_dd,
  output logic              clr_sec,
  output logic [FLD_W-1:0]  blink_mask
);

  localparam int unsigned IDLE_W = $clog2(TIMEOUT_S + 1);
  localparam int unsigned RPT_W  = $clog2(REPEAT_DLY + 1);
  localparam int unsigned BLK_W  = $clog2(BLINK_DIV + 1);

  logic [BTN_W-1:0] btn_edge;

  state_t            state_q, state_d;
  logic [FLD_W-1:0]  inc_q, inc_d;
  logic              clr_q, clr_d;
  logic              run_en_q, run_en_d;
  logic [FLD_W-1:0]  blink_q, blink_d;
  logic              touched_q, touched_d;
  logic [IDLE_W-1:0] idle_q, idle_d, idle_inc;
  logic [RPT_W-1:0]  rpt_q, rpt_d, rpt_inc;
  logic [BLK_W-1:0]  bcnt_q, bcnt_d, bcnt_inc;
  logic              phase_q, phase_d;
  logic              in_set, any_edge, rpt_fire, do_exit;

  for (genvar i = 0; i < int'(BTN_W); i++) begin : g_edge
    time_set_ctrl_edge u_edge (
      .clk   (clk),
      .rst   (rst),
      .din   (btn[i]),
      .pulse (btn_edge[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_RUN;
      inc_q     <= '0;
      clr_q     <= 1'b0;
      run_en_q  <= 1'b1;
      blink_q   <= '0;
      touched_q <= 1'b0;
      idle_q    <= '0;
      rpt_q     <= '0;
      bcnt_q    <= '0;
      phase_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      inc_q     <= inc_d;
      clr_q     <= clr_d;
      run_en_q  <= run_en_d;
      blink_q   <= blink_d;
      touched_q <= touched_d;
      idle_q    <= idle_d;
      rpt_q     <= rpt_d;
      bcnt_q    <= bcnt_d;
      phase_q   <= phase_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    inc_d     = '0;
    clr_d     = 1'b0;
    touched_d = touched_q;
    idle_d    = idle_q;
    rpt_d     = rpt_q;
    bcnt_d    = bcnt_q;
    phase_d   = phase_q;
    do_exit   = 1'b0;
    rpt_fire  = 1'b0;
    in_set    = |field_sel(state_q);
    any_edge  = |btn_edge;
    idle_inc  = idle_q + IDLE_W'(1);
    rpt_inc   = rpt_q + RPT_W'(1);
    bcnt_inc  = bcnt_q + BLK_W'(1);

    // Auto-repeat: first fire at REPEAT_DLY, then reload so each REPEAT_RATE ticks refire
    if (in_set && btn[BTN_UP]) begin
      if (tick_fast) begin
        if (rpt_inc == RPT_W'(REPEAT_DLY)) begin
          rpt_fire = 1'b1;
          rpt_d    = RPT_W'(REPEAT_DLY - REPEAT_RATE);
        end else begin
          rpt_d = rpt_inc;
        end
      end
    end else begin
      rpt_d = '0;
    end

    if (!in_set || any_edge) begin
      idle_d = '0;
    end else if (tick_1hz) begin
      idle_d = idle_inc;
    end

    // One command per cycle: CANCEL > MODE > UP > CLR; timeout only with no edge at all
    case (state_q)
      ST_RUN: begin
        if (btn_edge[BTN_MODE] && !btn_edge[BTN_CANCEL]) state_d = ST_SET_HR;
      end
      ST_SET_HR, ST_SET_MIN, ST_SET_MON, ST_SET_DAY: begin
        if (btn_edge[BTN_CANCEL]) begin
          do_exit = 1'b1;
        end else if (btn_edge[BTN_MODE]) begin
          case (state_q)
            ST_SET_HR:  state_d = ST_SET_MIN;
            ST_SET_MIN: state_d = ST_SET_MON;
            ST_SET_MON: state_d = ST_SET_DAY;
            default:    do_exit = 1'b1;
          endcase
        end else if (btn_edge[BTN_UP]) begin
          inc_d = field_sel(state_q);
        end else if (btn_edge[BTN_CLR]) begin
          clr_d = 1'b1;
        end else if (tick_1hz && idle_inc >= IDLE_W'(TIMEOUT_S)) begin
          do_exit = 1'b1;
        end else if (rpt_fire) begin
          inc_d = field_sel(state_q);
        end
      end
      default: state_d = ST_RUN;
    endcase

    if (do_exit) begin
      state_d   = ST_RUN;
      clr_d     = touched_q;
      touched_d = 1'b0;
    end else if (inc_d[FLD_MIN]) begin
      touched_d = 1'b1;
    end

    if (state_d == ST_RUN) idle_d = '0;
    if (state_d != state_q) rpt_d = '0;

    // Blink phase restarts visible on entry and is held visible while UP is down
    if (state_d == ST_RUN || btn[BTN_UP]) begin
      bcnt_d  = '0;
      phase_d = 1'b0;
    end else if (tick_fast) begin
      if (bcnt_inc == BLK_W'(BLINK_DIV)) begin
        bcnt_d  = '0;
        phase_d = ~phase_q;
      end else begin
        bcnt_d = bcnt_inc;
      end
    end

    run_en_d = (state_d == ST_RUN);
    blink_d  = phase_d ? field_sel(state_d) : '0;
  end

  assign mode       = state_q;
  assign run_en     = run_en_q;
  assign inc_hr     = inc_q[FLD_HR];
  assign inc_min    = inc_q[FLD_MIN];
  assign inc_mm     = inc_q[FLD_MM];
  assign inc_dd     = inc_q[FLD_DD];
  assign clr_sec    = clr_q;
  assign blink_mask = blink_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Scoreboard bench for time_set_ctrl: expected strobes (with arrival cycle)
// are queued as stimulus is driven and matched when the DUT emits them.
module tb_time_set_ctrl;
  import time_set_ctrl_pkg::*;

  // Strobe vector layout {clr_sec, inc_dd, inc_mm, inc_min, inc_hr}
  localparam logic [4:0] S_NONE = 5'b00000;
  localparam logic [4:0] S_HR   = 5'b00001;
  localparam logic [4:0] S_MIN  = 5'b00010;
  localparam logic [4:0] S_MM   = 5'b00100;
  localparam logic [4:0] S_DD   = 5'b01000;
  localparam logic [4:0] S_CLR  = 5'b10000;

  typedef struct {
    logic [4:0] vec;
    int         cyc;
  } exp_t;

  logic       clk, rst, tick_1hz, tick_fast;
  logic [3:0] btn;
  logic [2:0] mode;
  logic       run_en, inc_hr, inc_min, inc_mm, inc_dd, clr_sec;
  logic [3:0] blink_mask;

  exp_t       sb[$];
  exp_t       mon_e;
  logic [4:0] mon_v;
  int         n_checks = 0;
  int         n_errors = 0;
  int         cyc = 0;

  time_set_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .tick_1hz   (tick_1hz),
    .tick_fast  (tick_fast),
    .btn        (btn),
    .mode       (mode),
    .run_en     (run_en),
    .inc_hr     (inc_hr),
    .inc_min    (inc_min),
    .inc_mm     (inc_mm),
    .inc_dd     (inc_dd),
    .clr_sec    (clr_sec),
    .blink_mask (blink_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Monitor: every strobe must match the head of the scoreboard, on time
  always @(negedge clk) begin
    if (sb.size() != 0 && sb[0].cyc < cyc) begin
      mon_e = sb.pop_front();
      check("strobe_missing", 32'(S_NONE), 32'(mon_e.vec));
    end
    mon_v = {clr_sec, inc_dd, inc_mm, inc_min, inc_hr};
    if (mon_v != S_NONE) begin
      if (mon_v[3:0] != 4'b0) check("strobe_in_run", 32'(mode != 3'd0), 32'd1);
      if (sb.size() == 0) begin
        check("unexpected_strobe", 32'(mon_v), 32'(S_NONE));
      end else begin
        mon_e = sb.pop_front();
        check("strobe_vec", 32'(mon_v), 32'(mon_e.vec));
        check("strobe_cyc", 32'(cyc), 32'(mon_e.cyc));
      end
    end
  end

  task automatic tap(input int unsigned b, input logic [4:0] v);
    if (v != S_NONE) sb.push_back('{vec: v, cyc: cyc + 2});
    btn[b] = 1'b1;
    @(negedge clk);
    btn[b] = 1'b0;
    @(negedge clk);
  endtask

  task automatic tap2(input int unsigned a, input int unsigned b, input logic [4:0] v);
    if (v != S_NONE) sb.push_back('{vec: v, cyc: cyc + 2});
    btn[a] = 1'b1;
    btn[b] = 1'b1;
    @(negedge clk);
    btn[a] = 1'b0;
    btn[b] = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse_1hz();
    tick_1hz = 1'b1;
    @(negedge clk);
    tick_1hz = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse_fast(input logic [4:0] v);
    if (v != S_NONE) sb.push_back('{vec: v, cyc: cyc + 1});
    tick_fast = 1'b1;
    @(negedge clk);
    tick_fast = 1'b0;
    @(negedge clk);
  endtask

  task automatic modes(input int n);
    for (int i = 0; i < n; i++) tap(BTN_MODE, S_NONE);
  endtask

  initial begin
    repeat (20000) @(posedge clk);
    $display("FAIL watchdog: bench did not finish in cycle budget");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    rst       = 1'b1;
    btn       = 4'b0;
    tick_1hz  = 1'b0;
    tick_fast = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_mode", 32'(mode), 32'd0);
    check("rst_run_en", 32'(run_en), 32'd1);
    check("rst_blink", 32'(blink_mask), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Full MODE walk, no strobes
    for (int i = 1; i <= 5; i++) begin
      tap(BTN_MODE, S_NONE);
      check("walk_mode", 32'(mode), 32'(i % 5));
      check("walk_run_en", 32'(run_en), 32'(i == 5));
    end

    // Minute edits mark the set, so leaving via MODE clears seconds
    modes(2);
    check("min_mode", 32'(mode), 32'd2);
    repeat (3) tap(BTN_UP, S_MIN);
    modes(2);
    tap(BTN_MODE, S_CLR);
    check("min_exit_mode", 32'(mode), 32'd0);

    modes(2);
    tap(BTN_UP, S_MIN);
    tap(BTN_CANCEL, S_CLR);
    check("min_cancel_mode", 32'(mode), 32'd0);

    // Hold UP in SET_HR: edge strobe, then repeats on tick_fast 4,6,8,10,12
    modes(1);
    check("hr_mode", 32'(mode), 32'd1);
    sb.push_back('{vec: S_HR, cyc: cyc + 2});
    btn[BTN_UP] = 1'b1;
    repeat (2) @(negedge clk);
    for (int k = 1; k <= 12; k++) begin
      pulse_fast((k >= 4 && k % 2 == 0) ? S_HR : S_NONE);
      check("hold_blink", 32'(blink_mask), 32'd0);
    end
    btn[BTN_UP] = 1'b0;
    @(negedge clk);
    pulse_fast(S_NONE);
    check("blink_t1", 32'(blink_mask), 32'd0);
    pulse_fast(S_NONE);
    check("blink_t2", 32'(blink_mask), 32'b0001);
    pulse_fast(S_NONE);
    check("blink_t3", 32'(blink_mask), 32'b0001);
    pulse_fast(S_NONE);
    check("blink_t4", 32'(blink_mask), 32'd0);
    tap(BTN_CLR, S_CLR);
    tap2(BTN_UP, BTN_CLR, S_HR);
    check("upclr_mode", 32'(mode), 32'd1);
    tap2(BTN_MODE, BTN_CANCEL, S_NONE);
    check("hr_cancel_prio", 32'(mode), 32'd0);
    check("hr_cancel_blink", 32'(blink_mask), 32'd0);

    // Inactivity timeout in SET_MON
    modes(3);
    check("mon_mode", 32'(mode), 32'd3);
    check("mon_run_en", 32'(run_en), 32'd0);
    for (int k = 1; k <= 30; k++) begin
      pulse_1hz();
      check("timeout_mode", 32'(mode), (k == 30) ? 32'd0 : 32'd3);
    end
    check("timeout_run_en", 32'(run_en), 32'd1);

    // Button edge coinciding with the 30th tick wins and restarts the count
    modes(3);
    repeat (29) pulse_1hz();
    check("pre_edge_mode", 32'(mode), 32'd3);
    sb.push_back('{vec: S_MM, cyc: cyc + 2});
    btn[BTN_UP] = 1'b1;
    @(negedge clk);
    tick_1hz = 1'b1;
    @(negedge clk);
    tick_1hz = 1'b0;
    btn[BTN_UP] = 1'b0;
    check("edge_vs_timeout", 32'(mode), 32'd3);
    @(negedge clk);
    for (int k = 1; k <= 30; k++) begin
      pulse_1hz();
      check("retimeout_mode", 32'(mode), (k == 30) ? 32'd0 : 32'd3);
    end

    // RUN ignores UP/CLR/CANCEL
    tap(BTN_UP, S_NONE);
    tap(BTN_CLR, S_NONE);
    tap(BTN_CANCEL, S_NONE);
    check("run_ignore_mode", 32'(mode), 32'd0);

    modes(4);
    check("day_mode", 32'(mode), 32'd4);
    tap2(BTN_MODE, BTN_CANCEL, S_NONE);
    check("day_cancel_mode", 32'(mode), 32'd0);

    // Reset mid-repeat in SET_DAY
    modes(4);
    sb.push_back('{vec: S_DD, cyc: cyc + 2});
    btn[BTN_UP] = 1'b1;
    repeat (2) @(negedge clk);
    for (int k = 1; k <= 5; k++) pulse_fast((k == 4) ? S_DD : S_NONE);
    rst       = 1'b1;
    tick_fast = 1'b1;
    @(negedge clk);
    rst       = 1'b0;
    tick_fast = 1'b0;
    check("rst_mid_mode", 32'(mode), 32'd0);
    check("rst_mid_run_en", 32'(run_en), 32'd1);
    check("rst_mid_blink", 32'(blink_mask), 32'd0);
    btn[BTN_UP] = 1'b0;
    repeat (4) @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
